// File: rtl/shot_pkg.sv
// Shared definitions for Reimu's shot controller. The boss bullet engine and the renderer use them too.
// Holds the FSM state type, the coordinate width, the playfield limits, the launch offset
// and the per-slot payload struct.
package shot_pkg;

  localparam int unsigned COORD_W     = 10;
  // One extra bit so that sums and differences of coordinates cannot wrap.
  localparam int unsigned CALC_W      = COORD_W + 1;
  localparam int unsigned PF_Y_TOP    = 8;
  localparam int unsigned PF_Y_BOTTOM = 432;
  localparam int unsigned PF_X_RIGHT  = 472;
  localparam int unsigned LAUNCH_YOFS = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FIGHT    = 2'd1,
    ST_DEFEATED = 2'd2
  } shot_state_e;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } shot_slot_t;

  // Tells whether a point lies inside the visible playfield.
  function automatic logic in_playfield(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return (CALC_W'(x) <= CALC_W'(PF_X_RIGHT)) && (CALC_W'(y) <= CALC_W'(PF_Y_BOTTOM));
  endfunction

endpackage

// File: rtl/shot_slot.sv
// One player bullet slot. It holds a position, moves upward each active tick,
// retires at the top limit or on a boss hit, and loads a new shot when asked.
// Ports: clk22/rst (sync, active-high); active = fight tick; clear = drop the slot;
//        load/launch_x/launch_y = new shot; boss_x/boss_y = boss centre;
//        slot = registered {valid,x,y}; hit_c = combinational hit in the current tick.
module shot_slot
  import shot_pkg::*;
#(
  parameter int unsigned SPEED     = 16,
  parameter int unsigned HIT_HW    = 24,
  parameter int unsigned HIT_HH    = 24,
  parameter int unsigned TOP_LIMIT = PF_Y_TOP
) (
  input  logic               clk22,
  input  logic               rst,
  input  logic               active,
  input  logic               clear,
  input  logic               load,
  input  logic [COORD_W-1:0] launch_x,
  input  logic [COORD_W-1:0] launch_y,
  input  logic [COORD_W-1:0] boss_x,
  input  logic [COORD_W-1:0] boss_y,
  output shot_slot_t         slot,
  output logic               hit_c
);

  logic               valid_q, valid_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [CALC_W-1:0]  bx_w, by_w, tx_w, ty_w;
  logic               in_box;

  // Hit-box test on start-of-tick values, done in the widened domain.
  always_comb begin
    bx_w   = CALC_W'(x_q);
    by_w   = CALC_W'(y_q);
    tx_w   = CALC_W'(boss_x);
    ty_w   = CALC_W'(boss_y);
    in_box = (by_w + CALC_W'(HIT_HH) > ty_w) && (by_w < ty_w + CALC_W'(HIT_HH)) &&
             (bx_w + CALC_W'(HIT_HW) > tx_w) && (bx_w < tx_w + CALC_W'(HIT_HW));
  end

  assign hit_c = valid_q && active && in_box;

  // Move or retire the slot. A load only arrives for a slot that was free at the start of the tick.
  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    if (clear) begin
      valid_d = 1'b0;
      x_d     = '0;
      y_d     = '0;
    end else if (active) begin
      if (hit_c) begin
        valid_d = 1'b0;
      end else if (valid_q) begin
        if (by_w < CALC_W'(TOP_LIMIT + SPEED)) valid_d = 1'b0;
        else                                   y_d     = COORD_W'(by_w - CALC_W'(SPEED));
      end
      if (load) begin
        valid_d = 1'b1;
        x_d     = launch_x;
        y_d     = launch_y;
      end
    end
  end

  always_ff @(posedge clk22) begin
    if (rst) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign slot = '{valid: valid_q, x: x_q, y: y_q};

endmodule

// File: rtl/reimu_shot_ctrl.sv
// Reimu shot controller. It launches player shots, moves them through shot_slot instances,
// counts hits on the boss and tracks boss HP and defeat.
// Ports: clk22, rst (sync, active-high); boss = boss stage active; fire = fire key level;
//        reimux/reimuy = player centre; bossx/bossy = boss centre;
//        bullet_valid/bullet_x/bullet_y = slot state (slot i at [10i+9:10i]);
//        boss_hp = remaining HP; boss_hit = one-tick hit pulse; boss_defeated = HP reached 0.
// Build option: define POWER_SHOT_EN to make each hit remove 2 HP instead of 1.
module reimu_shot_ctrl
  import shot_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 4,
  parameter int unsigned SPEED        = 16,
  parameter int unsigned COOLDOWN     = 3,
  parameter int unsigned BOSS_HP_INIT = 100,
  parameter int unsigned HIT_HW       = 24,
  parameter int unsigned HIT_HH       = 24,
  parameter int unsigned TOP_LIMIT    = PF_Y_TOP
) (
  input  logic                         clk22,
  input  logic                         rst,
  input  logic                         boss,
  input  logic                         fire,
  input  logic [COORD_W-1:0]           reimux,
  input  logic [COORD_W-1:0]           reimuy,
  input  logic [COORD_W-1:0]           bossx,
  input  logic [COORD_W-1:0]           bossy,
  output logic [NUM_SLOTS-1:0]         bullet_valid,
  output logic [COORD_W*NUM_SLOTS-1:0] bullet_x,
  output logic [COORD_W*NUM_SLOTS-1:0] bullet_y,
  output logic [7:0]                   boss_hp,
  output logic                         boss_hit,
  output logic                         boss_defeated
);

  localparam int unsigned HP_W     = 8;
  localparam int unsigned HP_EXT_W = HP_W + 1;
  localparam int unsigned HITS_W   = $clog2(NUM_SLOTS + 1);
  localparam int unsigned DMG_W    = HITS_W + 2;
  localparam int unsigned CD_W     = 8;
`ifdef POWER_SHOT_EN
  localparam int unsigned DMG      = 2;
`else
  localparam int unsigned DMG      = 1;
`endif

  shot_state_e          state_q, state_d;
  logic [HP_W-1:0]      hp_q, hp_d;
  logic                 boss_hit_q, boss_hit_d;
  logic                 defeated_q, defeated_d;
  logic [CD_W-1:0]      cooldown_q, cooldown_d;

  shot_slot_t           slot_out [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_vec;
  logic [NUM_SLOTS-1:0] slot_hit;
  logic [NUM_SLOTS-1:0] slot_load;
  logic                 slot_clear;
  logic                 fight_tick;
  logic                 launch_ok;
  logic                 found;
  logic [HITS_W-1:0]    hits;
  logic [DMG_W-1:0]     dmg;
  logic [HP_W-1:0]      hp_after;
  logic [COORD_W-1:0]   launch_y;

  // A tick that runs bullet motion and hit tests. Losing boss while in FIGHT aborts to IDLE.
  assign fight_tick = (state_q == ST_FIGHT) && boss;
  assign launch_y   = reimuy - COORD_W'(LAUNCH_YOFS);

  // Count this tick's hits and apply the damage, saturating at 0.
  always_comb begin
    hits = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) hits = hits + HITS_W'(slot_hit[i]);
    dmg = DMG_W'(hits) * DMG_W'(DMG);
    if (HP_EXT_W'(dmg) >= HP_EXT_W'(hp_q)) hp_after = '0;
    else                                   hp_after = HP_W'(HP_EXT_W'(hp_q) - HP_EXT_W'(dmg));
  end

  // FSM state register.
  always_ff @(posedge clk22) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (boss) state_d = ST_FIGHT;
      ST_FIGHT: begin
        if (!boss)                state_d = ST_IDLE;
        else if (hp_after == '0)  state_d = ST_DEFEATED;
      end
      ST_DEFEATED: if (!boss) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the allocator, cooldown, HP and status next values.
  always_comb begin
    slot_load  = '0;
    found      = 1'b0;
    launch_ok  = fight_tick && (state_d == ST_FIGHT) && fire && (cooldown_q == '0) &&
                 (reimuy >= COORD_W'(LAUNCH_YOFS));
    // Only slots free at the start of the tick count. Slots that retire this tick wait one tick.
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!found && !valid_vec[i]) begin
        slot_load[i] = launch_ok;
        found        = 1'b1;
      end
    end
    slot_clear = (state_d != ST_FIGHT);

    if (|slot_load)             cooldown_d = CD_W'(COOLDOWN);
    else if (cooldown_q != '0)  cooldown_d = cooldown_q - CD_W'(1);
    else                        cooldown_d = cooldown_q;

    if (state_d == ST_IDLE) hp_d = HP_W'(BOSS_HP_INIT);
    else if (fight_tick)    hp_d = hp_after;
    else                    hp_d = hp_q;

    boss_hit_d = fight_tick && (hits != '0);
    defeated_d = (state_d == ST_DEFEATED);
  end

  always_ff @(posedge clk22) begin
    if (rst) begin
      hp_q       <= HP_W'(BOSS_HP_INIT);
      boss_hit_q <= 1'b0;
      defeated_q <= 1'b0;
      cooldown_q <= '0;
    end else begin
      hp_q       <= hp_d;
      boss_hit_q <= boss_hit_d;
      defeated_q <= defeated_d;
      cooldown_q <= cooldown_d;
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    shot_slot #(
      .SPEED     (SPEED),
      .HIT_HW    (HIT_HW),
      .HIT_HH    (HIT_HH),
      .TOP_LIMIT (TOP_LIMIT)
    ) u_slot (
      .clk22    (clk22),
      .rst      (rst),
      .active   (fight_tick),
      .clear    (slot_clear),
      .load     (slot_load[gi]),
      .launch_x (reimux),
      .launch_y (launch_y),
      .boss_x   (bossx),
      .boss_y   (bossy),
      .slot     (slot_out[gi]),
      .hit_c    (slot_hit[gi])
    );
    assign valid_vec[gi]                      = slot_out[gi].valid;
    assign bullet_x[COORD_W*gi +: COORD_W]    = slot_out[gi].x;
    assign bullet_y[COORD_W*gi +: COORD_W]    = slot_out[gi].y;
  end

  assign bullet_valid  = valid_vec;
  assign boss_hp       = hp_q;
  assign boss_hit      = boss_hit_q;
  assign boss_defeated = defeated_q;

endmodule

// File: tb/tb_reimu_shot_ctrl.sv
// Self-checking bench for reimu_shot_ctrl. A behavioural tick model pushes the expected outputs
// into a scoreboard queue and each clock edge pops and compares them.
module tb_reimu_shot_ctrl;

  localparam int NS = 4;
`ifdef POWER_SHOT_EN
  localparam int DMG_TB = 2;
`else
  localparam int DMG_TB = 1;
`endif

  logic        clk22 = 1'b0;
  logic        rst, boss, fire;
  logic [9:0]  reimux, reimuy, bossx, bossy;
  logic [3:0]  bullet_valid;
  logic [39:0] bullet_x, bullet_y;
  logic [7:0]  boss_hp;
  logic        boss_hit, boss_defeated;

  always #5 clk22 = ~clk22;

  reimu_shot_ctrl dut (
    .clk22         (clk22),
    .rst           (rst),
    .boss          (boss),
    .fire          (fire),
    .reimux        (reimux),
    .reimuy        (reimuy),
    .bossx         (bossx),
    .bossy         (bossy),
    .bullet_valid  (bullet_valid),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .boss_hp       (boss_hp),
    .boss_hit      (boss_hit),
    .boss_defeated (boss_defeated)
  );

  typedef struct {
    logic [3:0]  v;
    logic [39:0] x;
    logic [39:0] y;
    logic [7:0]  hp;
    logic        hit;
    logic        def;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: 0 idle, 1 fight, 2 defeated.
  int   m_state;
  bit   m_v[NS];
  int   m_x[NS];
  int   m_y[NS];
  int   m_hp, m_cd;
  bit   m_hit, m_def;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit nv[NS];
    int nx[NS];
    int ny[NS];
    int hits, nhp, rx, ry, bx, by;
    bit launched;
    hits = 0; launched = 0;
    rx = int'(reimux); ry = int'(reimuy); bx = int'(bossx); by = int'(bossy);
    if (rst) begin
      m_state = 0;
      for (int i = 0; i < NS; i++) begin m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      m_hp = 100; m_cd = 0; m_hit = 0; m_def = 0;
      return;
    end
    nv = m_v; nx = m_x; ny = m_y;
    if (m_state == 1 && boss) begin
      for (int i = 0; i < NS; i++) begin
        if (m_v[i]) begin
          if ((m_y[i] + 24 > by) && (m_y[i] < by + 24) && (m_x[i] + 24 > bx) && (m_x[i] < bx + 24)) begin
            nv[i] = 0; hits++;
          end else if (m_y[i] < 24) begin
            nv[i] = 0;
          end else begin
            ny[i] = m_y[i] - 16;
          end
        end
      end
      nhp = m_hp - hits * DMG_TB;
      if (nhp < 0) nhp = 0;
      m_hp = nhp;
      if (nhp == 0) begin
        m_state = 2;
        for (int i = 0; i < NS; i++) nv[i] = 0;
      end else if (fire && m_cd == 0 && ry >= 16) begin
        for (int i = 0; i < NS; i++) begin
          if (!m_v[i]) begin
            nv[i] = 1; nx[i] = rx; ny[i] = ry - 16; launched = 1;
            break;
          end
        end
      end
    end else if (m_state != 0) begin
      if (!boss) begin
        m_state = 0; m_hp = 100;
        for (int i = 0; i < NS; i++) nv[i] = 0;
      end
    end else if (boss) begin
      m_state = 1;
    end
    m_v = nv; m_x = nx; m_y = ny;
    if (launched)      m_cd = 3;
    else if (m_cd > 0) m_cd--;
    m_hit = (hits > 0);
    m_def = (m_state == 2);
  endtask

  // Drive one tick: model it, queue the expectation, clock, then pop and compare.
  task automatic step();
    exp_t        e;
    logic [39:0] gx, gy;
    model_step();
    e.v = '0; e.x = '0; e.y = '0;
    for (int i = 0; i < NS; i++) begin
      if (m_v[i]) begin
        e.v[i] = 1'b1;
        e.x[i*10 +: 10] = 10'(m_x[i]);
        e.y[i*10 +: 10] = 10'(m_y[i]);
      end
    end
    e.hp = 8'(m_hp); e.hit = m_hit; e.def = m_def;
    sb_q.push_back(e);
    @(posedge clk22);
    #1;
    e  = sb_q.pop_front();
    gx = bullet_x; gy = bullet_y;
    for (int i = 0; i < NS; i++) begin
      if (!e.v[i]) begin gx[i*10 +: 10] = '0; gy[i*10 +: 10] = '0; end
    end
    check("sb_valid", bullet_valid, e.v);
    check("sb_x", gx, e.x);
    check("sb_y", gy, e.y);
    check("sb_hp", boss_hp, e.hp);
    check("sb_hit", boss_hit, e.hit);
    check("sb_defeated", boss_defeated, e.def);
  endtask

  initial begin
    int pulses, n;
    rst = 1; boss = 0; fire = 0; reimux = 0; reimuy = 0; bossx = 0; bossy = 0;
    step(); step();
    check("rst_valid", bullet_valid, 0);
    check("rst_x", bullet_x, 0);
    check("rst_y", bullet_y, 0);
    check("rst_hp", boss_hp, 100);
    check("rst_defeated", boss_defeated, 0);

    // Fire held with the boss far away: fill, drop, retire at top, no reuse in the retire tick.
    rst = 0; boss = 1; fire = 1; reimux = 200; reimuy = 400; bossx = 600; bossy = 100;
    step();
    for (int t = 0; t <= 30; t++) begin
      reimuy = (t == 4) ? 10'd300 : 10'd400;
      step();
      if (t == 0) begin
        check("t2_first_v", bullet_valid, 4'b0001);
        check("t2_first_y", bullet_y[9:0], 384);
        check("t2_first_x", bullet_x[9:0], 200);
      end
      if (t == 12) check("t2_full", bullet_valid, 4'b1111);
      if (t == 16) check("t2_drop_full", bullet_valid, 4'b1111);
      if (t == 22) check("t6_no_reuse", bullet_valid, 4'b1101);
      if (t == 23) begin
        check("t6_reuse", bullet_valid, 4'b1111);
        check("t6_reuse_y", bullet_y[19:10], 384);
      end
      if (t == 24) check("t2_top_retire", bullet_valid, 4'b1110);
    end
    boss = 0; fire = 1;
    for (int i = 0; i < 4; i++) step();
    check("idle_clear", bullet_valid, 0);

    // Single shot into the boss hit-box.
    boss = 1; fire = 0; reimux = 200; reimuy = 400; bossx = 200; bossy = 100;
    step();
    fire = 1; step(); fire = 0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (boss_hit) pulses++;
    end
    check("t3_pulses", pulses, 1);
    check("t3_hp", boss_hp, 100 - DMG_TB);
    check("t3_valid", bullet_valid, 0);

    // Reset in the middle of a fight with three slots in flight.
    bossx = 600; fire = 1;
    for (int i = 0; i < 9; i++) step();
    check("t1_pre", bullet_valid, 4'b0111);
    rst = 1; step(); rst = 0;
    check("t1_valid", bullet_valid, 0);
    check("t1_hp", boss_hp, 100);
    step();
    check("t1_idle", bullet_valid, 0);

    // Launch suppressed near the top edge; fire ignored once the boss leaves.
    reimuy = 10; fire = 1;
    for (int i = 0; i < 6; i++) step();
    check("t5_suppressed", bullet_valid, 0);
    reimuy = 400; step();
    check("t5_no_cooldown", bullet_valid, 4'b0001);
    boss = 0;
    for (int i = 0; i < 6; i++) step();
    check("t5_outside_fight", bullet_valid, 0);

    // Wear HP down, then land two hits in one tick.
    boss = 1; fire = 1; reimux = 200; reimuy = 400; bossx = 200; bossy = 384;
    step();
    n = 0;
    while (m_hp > DMG_TB && n < 1000) begin step(); n++; end
    check("t4_grind_bound", n < 1000, 1);
    fire = 0; bossx = 600;
    for (int i = 0; i < 4; i++) step();
    fire = 1; reimuy = 400; step();
    fire = 0;
    for (int i = 0; i < 3; i++) step();
    fire = 1; reimuy = 336; step();
    check("t4_pair_v", bullet_valid, 4'b0011);
    check("t4_pair_y0", bullet_y[9:0], 320);
    check("t4_pair_y1", bullet_y[19:10], 320);
    bossx = 200; bossy = 320; step();
    check("t4_hp_zero", boss_hp, 0);
    check("t4_defeated", boss_defeated, 1);
    check("t4_cleared", bullet_valid, 0);
    check("t4_hit", boss_hit, 1);
    for (int i = 0; i < 5; i++) step();
    check("t4_fire_ignored", bullet_valid, 0);
    check("t4_hp_hold", boss_hp, 0);
    boss = 0; step();
    check("t4_reload_hp", boss_hp, 100);
    check("t4_defeated_clr", boss_defeated, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      boss   = ($urandom_range(0, 19) != 0);
      fire   = ($urandom_range(0, 3) != 0);
      reimux = 10'($urandom_range(0, 1023));
      reimuy = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 20)) : 10'($urandom_range(0, 1023));
      bossx  = ($urandom_range(0, 1) == 0) ? reimux : 10'($urandom_range(0, 1023));
      bossy  = 10'($urandom_range(0, 600));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
